tap_accumulator_9: RTL and testbench



---
 rtl/tap_accumulator_9.sv | 104 ++++++++++
 tb/tb_tap_accumulator_9.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tap_accumulator_9.sv
// Consumer end of the 9-tap sequencer: multiply-accumulates one 3x3 window per 9 in-order taps.
// Define TAP_ACC_SAT_EN to saturate the result to OUT_W; otherwise it wraps.
module tap_accumulator_9 #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tap_valid,
  input  logic [3:0]               tap_idx,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     tap_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     seq_error,
  output logic [15:0]              win_count
);

  localparam logic [3:0] LAST_IDX = 4'd8;

  logic signed [ACC_W-1:0]    acc_reg;
  logic [3:0]                 expected_reg;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    result;
  logic [OUT_W-1:0]           conv_data;
  logic                       accept;
  logic                       in_order;
  logic                       closing;

  assign product     = pixel * weight;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
  assign result      = acc_reg + product_ext;

  // Only the closing tap waits on an unread result; earlier taps keep flowing.
  assign tap_ready = ~(out_valid & ~out_ready & (expected_reg == LAST_IDX));
  assign accept    = tap_valid & tap_ready;
  assign in_order  = (tap_idx == expected_reg);
  assign closing   = accept & in_order & (expected_reg == LAST_IDX);

`ifdef TAP_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    conv_data = result[OUT_W-1:0];
    if (result > SAT_MAX)
      conv_data = SAT_MAX[OUT_W-1:0];
    else if (result < SAT_MIN)
      conv_data = SAT_MIN[OUT_W-1:0];
  end
`else
  always_comb begin
    conv_data = result[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      expected_reg <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      seq_error    <= 1'b0;
      win_count    <= '0;
    end else begin
      if (accept) begin
        if (in_order) begin
          if (expected_reg == 4'd0) begin
            acc_reg      <= product_ext;
            expected_reg <= 4'd1;
          end else if (expected_reg == LAST_IDX) begin
            acc_reg      <= '0;
            expected_reg <= 4'd0;
            out_data     <= conv_data;
            win_count    <= win_count + 16'd1;
          end else begin
            acc_reg      <= result;
            expected_reg <= expected_reg + 4'd1;
          end
        end else begin
          // An out-of-order index 0 is treated as the start of a fresh window.
          seq_error <= 1'b1;
          if (tap_idx == 4'd0) begin
            acc_reg      <= product_ext;
            expected_reg <= 4'd1;
          end else begin
            acc_reg      <= '0;
            expected_reg <= 4'd0;
          end
        end
      end

      if (closing)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_accumulator_9.sv
// Directed-vector bench for tap_accumulator_9; expected values are hand-computed per window.
module tb_tap_accumulator_9;

  logic              clk;
  logic              reset;
  logic              tap_valid;
  logic [3:0]        tap_idx;
  logic signed [7:0] pixel;
  logic signed [7:0] weight;
  logic              tap_ready;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;
  logic              seq_error;
  logic [15:0]       win_count;

  int checks;
  int fails;

`ifdef TAP_ACC_SAT_EN
  localparam int EXP_POS_FULL = 32767;
  localparam int EXP_NEG_FULL = -32768;
`else
  localparam int EXP_POS_FULL = 14089;
  localparam int EXP_NEG_FULL = -15232;
`endif

  tap_accumulator_9 dut (
    .clk       (clk),
    .reset     (reset),
    .tap_valid (tap_valid),
    .tap_idx   (tap_idx),
    .pixel     (pixel),
    .weight    (weight),
    .tap_ready (tap_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .seq_error (seq_error),
    .win_count (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One beat presented for exactly one rising edge; outputs then settle 1ns later.
  task automatic send(input int idx, input int p, input int w);
    @(negedge clk);
    tap_valid = 1'b1;
    tap_idx   = 4'(idx);
    pixel     = 8'(p);
    weight    = 8'(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    tap_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b0;
    tap_valid = 1'b0;
    tap_idx   = '0;
    pixel     = '0;
    weight    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_win_count", int'(win_count), 0);
    check("rst_seq_error", int'(seq_error), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_tap_ready", int'(tap_ready), 1);

    // Window 1: pixels 1, weights 1..9 -> 45
    for (int i = 0; i < 8; i++) send(i, 1, i + 1);
    check("w1_no_early_valid", int'(out_valid), 0);
    send(8, 1, 9);
    check("w1_out_valid", int'(out_valid), 1);
    check("w1_out_data",  int'(out_data), 45);
    check("w1_win_count", int'(win_count), 1);
    check("w1_seq_error", int'(seq_error), 0);
    idle();
    check("w1_popped", int'(out_valid), 0);

    // Window 2: full-scale positive products
    for (int i = 0; i < 9; i++) send(i, 127, 127);
    check("w2_out_data",  int'(out_data), EXP_POS_FULL);
    check("w2_win_count", int'(win_count), 2);

    // Window 3: full-scale negative products
    for (int i = 0; i < 9; i++) send(i, -128, 127);
    check("w3_out_data",  int'(out_data), EXP_NEG_FULL);
    check("w3_win_count", int'(win_count), 3);

    // Skipped index 3 -> sticky fault, then a clean window of pixel 1 weight 2 -> 18
    send(0, 1, 1);
    send(1, 1, 1);
    send(2, 1, 1);
    check("seq_before_fault", int'(seq_error), 0);
    send(4, 1, 1);
    check("seq_after_fault", int'(seq_error), 1);
    for (int i = 0; i < 9; i++) send(i, 1, 2);
    check("w4_out_data",  int'(out_data), 18);
    check("w4_seq_sticky", int'(seq_error), 1);
    check("w4_win_count", int'(win_count), 4);
    idle();

    // Backpressure: A=45 held unread, B (pixel 3, weight 1) -> 27 stalls on its tap 8
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(i, 1, i + 1);
    check("bp_a_valid", int'(out_valid), 1);
    check("bp_a_data",  int'(out_data), 45);
    for (int i = 0; i < 8; i++) send(i, 3, 1);
    check("bp_b_flowed_data", int'(out_data), 45);
    check("bp_tap_ready_low", int'(tap_ready), 0);
    send(8, 3, 1);
    send(8, 3, 1);
    check("bp_hold_data",  int'(out_data), 45);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_ready", int'(tap_ready), 0);
    check("bp_hold_count", int'(win_count), 5);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(tap_ready), 1);
    @(posedge clk);
    #1;
    check("bp_b_valid", int'(out_valid), 1);
    check("bp_b_data",  int'(out_data), 27);
    check("bp_b_count", int'(win_count), 6);
    idle();
    check("bp_b_popped", int'(out_valid), 0);

    // Reset mid-window after tap 5, then a fresh window must sum cleanly
    for (int i = 0; i < 6; i++) send(i, 5, 5);
    @(negedge clk);
    tap_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("mid_rst_out_data",  int'(out_data), 0);
    check("mid_rst_seq_error", int'(seq_error), 0);
    check("mid_rst_win_count", int'(win_count), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) send(i, 1, i + 1);
    check("post_rst_no_valid", int'(out_valid), 0);
    send(8, 1, 9);
    check("post_rst_valid",     int'(out_valid), 1);
    check("post_rst_data",      int'(out_data), 45);
    check("post_rst_win_count", int'(win_count), 1);
    check("post_rst_seq_error", int'(seq_error), 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
